rx: RTL and testbench

RX -- requirements
Module: rx

---
 rtl/rx.sv | 216 +++++++++++++++++++++
 tb/tb_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rx.sv
// ---------------------------------------------------------------------------
// rx : UART-style serial receiver (1 start, 8 data LSB first, 1 parity, 1 stop)
//
// Parameters
//   CLK_FREQUENCY : clk frequency in Hz
//   BAUD_RATE     : serial bit rate in bits/s
//   PARITY        : parity sense, 1 = odd, 0 = even
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   Sin        : asynchronous serial line, idle high
//   ReceiveAck : consumer acknowledge of the byte in Dout
//   Receive    : byte available (held until acknowledged)
//   Dout       : received data byte
//   parityErr  : parity mismatch on the byte in Dout
//
// Build option
//   RX_STOP_CHECK_EN : when defined, a frame whose stop sample is 0 is
//                      discarded and the receiver waits for Sin=1 before
//                      re-arming. Undefined (default): stop bit ignored.
// ---------------------------------------------------------------------------
module rx #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 19_200,
  parameter logic        PARITY        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Sin,
  input  logic       ReceiveAck,
  output logic       Receive,
  output logic [7:0] Dout,
  output logic       parityErr
);

  localparam int unsigned BIT_CYCLES  = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  // Timer only ever counts 0 .. BIT_CYCLES-1
  localparam int unsigned TIMER_W     = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(BIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_ACK       = 3'd5;
`ifdef RX_STOP_CHECK_EN
  localparam logic [2:0] S_WAIT_HIGH = 3'd6;
`endif

  // Registers
  logic               r_sin_meta;
  logic               r_sin_sync;
  logic [2:0]         r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_par_err;
  logic               r_receive;
  logic [7:0]         r_dout;
  logic               r_parity_err;

  // Next-state values
  logic [2:0]         w_state_next;
  logic [TIMER_W-1:0] w_timer_next;
  logic [2:0]         w_bit_cnt_next;
  logic [7:0]         w_shift_next;
  logic               w_par_err_next;
  logic               w_receive_next;
  logic [7:0]         w_dout_next;
  logic               w_parity_err_next;
  logic               w_bit_done;
  logic               w_half_done;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sin_meta <= 1'b1;
      r_sin_sync <= 1'b1;
    end else begin
      r_sin_meta <= Sin;
      r_sin_sync <= r_sin_meta;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_receive    <= 1'b0;
      r_dout       <= 8'h00;
      r_parity_err <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_shift      <= w_shift_next;
      r_par_err    <= w_par_err_next;
      r_receive    <= w_receive_next;
      r_dout       <= w_dout_next;
      r_parity_err <= w_parity_err_next;
    end
  end

  assign w_bit_done  = (r_timer == BIT_LAST);
  assign w_half_done = (r_timer == HALF_LAST);

  // Next-state and datapath decode
  always_comb begin
    w_state_next      = r_state;
    w_timer_next      = r_timer + TIMER_W'(1);
    w_bit_cnt_next    = r_bit_cnt;
    w_shift_next      = r_shift;
    w_par_err_next    = r_par_err;
    w_dout_next       = r_dout;
    w_parity_err_next = r_parity_err;
    // Receive lags the ACK state by one cycle: rises the cycle after the
    // stop sample, falls the edge after the acknowledge is taken.
    w_receive_next    = (r_state == S_ACK);

    case (r_state)
      S_IDLE: begin
        w_timer_next = '0;
        if (!r_sin_sync) begin
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (w_half_done) begin
          w_timer_next = '0;
          if (!r_sin_sync) begin
            w_state_next   = S_DATA;
            w_bit_cnt_next = '0;
          end else begin
            w_state_next = S_IDLE;   // short low pulse: not a start bit
          end
        end
      end

      S_DATA: begin
        if (w_bit_done) begin
          w_timer_next   = '0;
          w_shift_next   = {r_sin_sync, r_shift[7:1]};   // LSB arrives first
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_next = S_PARITY;
          end
        end
      end

      S_PARITY: begin
        if (w_bit_done) begin
          w_timer_next   = '0;
          // Error when sampled bit differs from (XOR of data) XOR PARITY
          w_par_err_next = (^r_shift) ^ PARITY ^ r_sin_sync;
          w_state_next   = S_STOP;
        end
      end

      S_STOP: begin
        if (w_bit_done) begin
          w_timer_next = '0;
`ifdef RX_STOP_CHECK_EN
          if (r_sin_sync) begin
            w_dout_next       = r_shift;
            w_parity_err_next = r_par_err;
            w_state_next      = S_ACK;
          end else begin
            w_state_next = S_WAIT_HIGH;   // framing error: drop the byte
          end
`else
          w_dout_next       = r_shift;
          w_parity_err_next = r_par_err;
          w_state_next      = S_ACK;
`endif
        end
      end

      S_ACK: begin
        // Line is ignored here; a frame starting now is lost
        w_timer_next = '0;
        if (ReceiveAck) begin
          w_state_next = S_IDLE;
        end
      end

`ifdef RX_STOP_CHECK_EN
      S_WAIT_HIGH: begin
        w_timer_next = '0;
        if (r_sin_sync) begin
          w_state_next = S_IDLE;
        end
      end
`endif

      default: begin
        w_timer_next = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign Receive   = r_receive;
  assign Dout      = r_dout;
  assign parityErr = r_parity_err;

endmodule

// File: tb/tb_rx.sv
// ---------------------------------------------------------------------------
// tb_rx : directed bench for rx. Bit rate is scaled to 16 clocks per bit so
// the whole run stays short; the glitch length scales with it.
// ---------------------------------------------------------------------------
module tb_rx;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned BAUD   = 6_250_000;
  localparam int          BITC   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       Sin;
  logic       ReceiveAck;
  logic       Receive;
  logic [7:0] Dout;
  logic       parityErr;

  rx #(
    .CLK_FREQUENCY(CLK_HZ),
    .BAUD_RATE    (BAUD),
    .PARITY       (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Sin       (Sin),
    .ReceiveAck(ReceiveAck),
    .Receive   (Receive),
    .Dout      (Dout),
    .parityErr (parityErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   rise_cnt = 0;
  int   exp_rise = 0;
  logic prev_rcv = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    Sin = b;
    tick(BITC);
  endtask

  // Full frame; expected result goes to the scoreboard as it is driven
  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    exp_t e;
    logic pbit;
    pbit = (^d) ^ 1'b1 ^ bad_par;
    e.d  = d;
    e.pe = bad_par;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(1'b1);
  endtask

  task automatic wait_rise(input string tag, input int target);
    for (int i = 0; i < 6 * BITC && rise_cnt < target; i++) tick(1);
    check(tag, 32'(rise_cnt), 32'(target));
  endtask

  task automatic ack_and_check(input string tag);
    ReceiveAck = 1'b1;
    tick(2);
    check(tag, 32'(Receive), 32'(0));
    ReceiveAck = 1'b0;
  endtask

  // Scoreboard side: compare on every rising Receive, sampled mid-cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (Receive === 1'b1 && prev_rcv === 1'b0) begin
      rise_cnt++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("dout", 32'(Dout), 32'(e.d));
        check("parity_err", 32'(parityErr), 32'(e.pe));
      end
    end
    prev_rcv = Receive;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] bytes [8];
    bytes = '{8'hff, 8'h00, 8'h0f, 8'hf0, 8'h37, 8'h73, 8'haa, 8'h55};

    // Reset and idle line
    rst        = 1'b1;
    Sin        = 1'b1;
    ReceiveAck = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);
    check("rst_receive", 32'(Receive), 32'(0));
    check("rst_dout", 32'(Dout), 32'(8'h00));
    check("rst_parity_err", 32'(parityErr), 32'(0));

    // Good-parity bytes; one of them with ReceiveAck held high throughout
    for (int i = 0; i < 8; i++) begin
      if (i == 6) ReceiveAck = 1'b1;
      send_frame(bytes[i], 1'b0);
      exp_rise++;
      wait_rise("byte_rise", exp_rise);
      if (i != 6) check("rcv_held", 32'(Receive), 32'(1));
      ack_and_check("rcv_falls");
      tick(BITC);
    end

    // Inverted parity bit
    send_frame(8'h37, 1'b1);
    exp_rise++;
    wait_rise("badpar_rise", exp_rise);
    ack_and_check("badpar_falls");
    tick(BITC);

    // Short low glitch must not start a frame
    Sin = 1'b0;
    tick(3);
    Sin = 1'b1;
    tick(4 * BITC);
    check("glitch_no_rcv", 32'(rise_cnt), 32'(exp_rise));
    send_frame(8'haa, 1'b0);
    exp_rise++;
    wait_rise("after_glitch_rise", exp_rise);
    ack_and_check("after_glitch_falls");
    tick(BITC);

    // Reset in the middle of the data bits of 8'h55
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b1;
    #1;
    check("midrst_receive", 32'(Receive), 32'(0));
    check("midrst_dout", 32'(Dout), 32'(8'h00));
    check("midrst_parity_err", 32'(parityErr), 32'(0));
    Sin = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4 * BITC);
    check("midrst_no_rcv", 32'(rise_cnt), 32'(exp_rise));
    check("midrst_dout_hold", 32'(Dout), 32'(8'h00));
    send_frame(8'h0f, 1'b0);
    exp_rise++;
    wait_rise("after_rst_rise", exp_rise);
    ack_and_check("after_rst_falls");
    tick(BITC);

    // Delayed acknowledge: Receive and Dout hold for three bit times
    send_frame(8'h73, 1'b0);
    exp_rise++;
    wait_rise("hold_rise", exp_rise);
    for (int i = 0; i < 3 * BITC; i++) begin
      check("hold_receive", 32'(Receive), 32'(1));
      check("hold_dout", 32'(Dout), 32'(8'h73));
      tick(1);
    end
    ack_and_check("hold_falls");
    tick(2 * BITC);
    check("single_rise", 32'(rise_cnt), 32'(exp_rise));
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
